multiexp_stream_core: RTL and testbench

Next-generation multi-scalar multiplication core. It consumes a looping stream of {point, scalar} pairs and accumulates the sum of scalar_i·P_i with MSB-first interleaved double-and-add. Point addition and doubling are delegated to external ec_point_add / ec_point_dbl units over AXI-stream request/response interfaces. Over the previous core it adds:

- a runtime input count,
- leading-zero column skipping,
- accumulator-at-infinity bypass,
- three operating modes,
- error reporting.

---
 rtl/multiexp_stream_core.sv | 245 ++++++++++++++++++++++++
 tb/tb_multiexp_stream_core.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiexp_stream_core.sv
// Multi-scalar multiplication core: MSB-first interleaved double-and-add over a looping
// {point, scalar} stream, with point add/double delegated to external units.
module multiexp_stream_core #(
  parameter type FP_TYPE  = logic [511:0],
  parameter type FE_TYPE  = logic [255:0],
  parameter int  KEY_BITS = 256,
  parameter int  MAX_IN   = 1024,
  parameter int  CTL_BITS = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [$clog2(MAX_IN+1)-1:0]       i_num_in,
  // pair stream sink
  input  logic                              i_pnt_scl_val,
  output logic                              o_pnt_scl_rdy,
  input  logic [$bits(FP_TYPE)+$bits(FE_TYPE)-1:0] i_pnt_scl_dat,
  input  logic [CTL_BITS-1:0]               i_pnt_scl_ctl,
  // result source
  output logic                              o_pnt_val,
  input  logic                              i_pnt_rdy,
  output logic [$bits(FP_TYPE)-1:0]         o_pnt_dat,
  output logic [CTL_BITS-1:0]               o_pnt_ctl,
  output logic                              o_pnt_sop,
  output logic                              o_pnt_eop,
  // adder request / response
  output logic                              o_add_req_val,
  input  logic                              i_add_req_rdy,
  output logic [2*$bits(FP_TYPE)-1:0]       o_add_req_dat,
  input  logic                              i_add_rsp_val,
  output logic                              o_add_rsp_rdy,
  input  logic [$bits(FP_TYPE)-1:0]         i_add_rsp_dat,
  input  logic                              i_add_rsp_err,
  // doubler request / response
  output logic                              o_dbl_req_val,
  input  logic                              i_dbl_req_rdy,
  output logic [$bits(FP_TYPE)-1:0]         o_dbl_req_dat,
  input  logic                              i_dbl_rsp_val,
  output logic                              o_dbl_rsp_rdy,
  input  logic [$bits(FP_TYPE)-1:0]         i_dbl_rsp_dat,
  output logic                              o_err,
  output logic                              o_busy
);

  localparam int FPW = $bits(FP_TYPE);
  localparam int FEW = $bits(FE_TYPE);
  localparam int NW  = $clog2(MAX_IN+1);
  localparam int KW  = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_ADD_REQ  = 3'd2,
    ST_ADD_WAIT = 3'd3,
    ST_DBL_REQ  = 3'd4,
    ST_DBL_WAIT = 3'd5,
    ST_OUT      = 3'd6
  } state_t;

  state_t                r_state;
  logic [FPW-1:0]        r_acc;
  logic [FPW-1:0]        r_pnt;
  logic [FPW-1:0]        r_result;
  logic [KW-1:0]         r_key;
  logic [NW-1:0]         r_in_cnt;
  logic [NW-1:0]         r_num;
  logic [1:0]            r_mode;
  logic [CTL_BITS-1:0]   r_ctl;
  logic                  r_first;
  logic                  r_err_pend;
  logic                  r_err;

  logic [FEW-1:0]        w_scl;
  logic [FPW-1:0]        w_pnt;
  logic                  w_bit;
  logic                  w_acc_zero;
  logic                  w_col_end;
  logic [FPW-1:0]        w_acc_col;
  logic                  w_col_zero;
  state_t                w_nx_state;
  logic [KW-1:0]         w_nx_key;
  logic [NW-1:0]         w_nx_in;

  assign w_scl      = i_pnt_scl_dat[FEW-1:0];
  assign w_pnt      = i_pnt_scl_dat[FEW +: FPW];
  assign w_bit      = w_scl[r_key];
  assign w_acc_zero = (r_acc == {FPW{1'b0}});
  assign w_col_end  = (r_in_cnt == (r_num - NW'(1)));
  assign w_col_zero = (w_acc_col == {FPW{1'b0}});

  // Accumulator value seen by the end-of-column check (after bypass, no-op or add).
  always_comb begin
    w_acc_col = r_acc;
    if (r_state == ST_ADD_WAIT) begin
      w_acc_col = i_add_rsp_dat;
    end else if (w_bit && w_acc_zero) begin
      w_acc_col = w_pnt;
    end else begin
      w_acc_col = r_acc;
    end
  end

  // End-of-column decision: advance beat, finish, skip an all-zero column, or double.
  always_comb begin
    w_nx_state = ST_SCAN;
    w_nx_key   = r_key;
    w_nx_in    = r_in_cnt;
    if (!w_col_end) begin
      w_nx_in = r_in_cnt + NW'(1);
    end else if (r_key == {KW{1'b0}}) begin
      w_nx_state = ST_OUT;
    end else if (w_col_zero) begin
      w_nx_key = r_key - KW'(1);
      w_nx_in  = {NW{1'b0}};
    end else begin
      w_nx_state = ST_DBL_REQ;
    end
  end

  // Main control FSM and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= {FPW{1'b0}};
      r_pnt      <= {FPW{1'b0}};
      r_result   <= {FPW{1'b0}};
      r_key      <= KW'(KEY_BITS-1);
      r_in_cnt   <= {NW{1'b0}};
      r_num      <= NW'(1);
      r_mode     <= 2'd0;
      r_ctl      <= {CTL_BITS{1'b0}};
      r_first    <= 1'b0;
      r_err_pend <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_acc    <= {FPW{1'b0}};
          r_key    <= KW'(KEY_BITS-1);
          r_in_cnt <= {NW{1'b0}};
          if (i_pnt_scl_val) begin
            r_mode     <= i_pnt_scl_ctl[1:0];
            r_ctl      <= i_pnt_scl_ctl;
            r_num      <= ((i_pnt_scl_ctl[1:0] == 2'd2) || (i_num_in == {NW{1'b0}})) ? NW'(1) : i_num_in;
            r_err_pend <= ((i_pnt_scl_ctl[1:0] == 2'd0) && (i_num_in == {NW{1'b0}})) ||
                          (i_pnt_scl_ctl[1:0] == 2'd3);
            r_first    <= 1'b1;
            r_state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (i_pnt_scl_val) begin
            r_first <= 1'b0;
            if (r_first) begin
              r_err <= r_err_pend;
            end
            case (r_mode)
              2'd3: begin
                r_acc   <= {FPW{1'b0}};
                r_state <= ST_OUT;
              end
              2'd1: begin
                // single add against the retained result; infinity turns it into a load
                if (r_result == {FPW{1'b0}}) begin
                  r_acc   <= w_pnt;
                  r_state <= ST_OUT;
                end else begin
                  r_acc   <= r_result;
                  r_pnt   <= w_pnt;
                  r_state <= ST_ADD_REQ;
                end
              end
              default: begin
                if (w_bit && !w_acc_zero) begin
                  r_pnt   <= w_pnt;
                  r_state <= ST_ADD_REQ;
                end else begin
                  r_acc    <= w_acc_col;
                  r_state  <= w_nx_state;
                  r_key    <= w_nx_key;
                  r_in_cnt <= w_nx_in;
                end
              end
            endcase
          end
        end
        ST_ADD_REQ: begin
          if (i_add_req_rdy) begin
            r_state <= ST_ADD_WAIT;
          end
        end
        ST_ADD_WAIT: begin
          if (i_add_rsp_val) begin
            r_acc <= i_add_rsp_dat;
            r_err <= r_err | i_add_rsp_err;
            if (r_mode == 2'd1) begin
              r_state <= ST_OUT;
            end else begin
              r_state  <= w_nx_state;
              r_key    <= w_nx_key;
              r_in_cnt <= w_nx_in;
            end
          end
        end
        ST_DBL_REQ: begin
          if (i_dbl_req_rdy) begin
            r_state <= ST_DBL_WAIT;
          end
        end
        ST_DBL_WAIT: begin
          if (i_dbl_rsp_val) begin
            r_acc    <= i_dbl_rsp_dat;
            r_key    <= r_key - KW'(1);
            r_in_cnt <= {NW{1'b0}};
            r_state  <= ST_SCAN;
          end
        end
        ST_OUT: begin
          if (i_pnt_rdy) begin
            r_result <= r_acc;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_pnt_scl_rdy = (r_state == ST_SCAN);
  assign o_pnt_val     = (r_state == ST_OUT);
  assign o_pnt_dat     = r_acc;
  assign o_pnt_ctl     = r_ctl;
  assign o_pnt_sop     = 1'b1;
  assign o_pnt_eop     = 1'b1;
  assign o_add_req_val = (r_state == ST_ADD_REQ);
  assign o_add_req_dat = {r_acc, r_pnt};
  assign o_add_rsp_rdy = (r_state == ST_ADD_WAIT);
  assign o_dbl_req_val = (r_state == ST_DBL_REQ);
  assign o_dbl_req_dat = r_acc;
  assign o_dbl_rsp_rdy = (r_state == ST_DBL_WAIT);
  assign o_err         = r_err;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_multiexp_stream_core.sv
// Directed bench for multiexp_stream_core; points are modelled as integer multiples of G
// (0 = infinity), so the adder sums and the doubler multiplies by two.
module tb_multiexp_stream_core;
  localparam int KB  = 4;
  localparam int MI  = 8;
  localparam int CB  = 8;
  localparam int FPW = 16;
  localparam int FEW = 8;
  localparam int NW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NW-1:0]      i_num_in = '0;
  logic               i_pnt_scl_val, o_pnt_scl_rdy;
  logic [FPW+FEW-1:0] i_pnt_scl_dat;
  logic [CB-1:0]      i_pnt_scl_ctl;
  logic               o_pnt_val, i_pnt_rdy, o_pnt_sop, o_pnt_eop;
  logic [FPW-1:0]     o_pnt_dat;
  logic [CB-1:0]      o_pnt_ctl;
  logic               o_add_req_val, i_add_req_rdy, i_add_rsp_val, o_add_rsp_rdy, i_add_rsp_err;
  logic [2*FPW-1:0]   o_add_req_dat;
  logic [FPW-1:0]     i_add_rsp_dat;
  logic               o_dbl_req_val, i_dbl_req_rdy, i_dbl_rsp_val, o_dbl_rsp_rdy;
  logic [FPW-1:0]     o_dbl_req_dat, i_dbl_rsp_dat;
  logic               o_err, o_busy;

  multiexp_stream_core #(
    .FP_TYPE(logic [FPW-1:0]), .FE_TYPE(logic [FEW-1:0]),
    .KEY_BITS(KB), .MAX_IN(MI), .CTL_BITS(CB)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_num_in(i_num_in),
    .i_pnt_scl_val(i_pnt_scl_val), .o_pnt_scl_rdy(o_pnt_scl_rdy),
    .i_pnt_scl_dat(i_pnt_scl_dat), .i_pnt_scl_ctl(i_pnt_scl_ctl),
    .o_pnt_val(o_pnt_val), .i_pnt_rdy(i_pnt_rdy), .o_pnt_dat(o_pnt_dat),
    .o_pnt_ctl(o_pnt_ctl), .o_pnt_sop(o_pnt_sop), .o_pnt_eop(o_pnt_eop),
    .o_add_req_val(o_add_req_val), .i_add_req_rdy(i_add_req_rdy), .o_add_req_dat(o_add_req_dat),
    .i_add_rsp_val(i_add_rsp_val), .o_add_rsp_rdy(o_add_rsp_rdy),
    .i_add_rsp_dat(i_add_rsp_dat), .i_add_rsp_err(i_add_rsp_err),
    .o_dbl_req_val(o_dbl_req_val), .i_dbl_req_rdy(i_dbl_req_rdy), .o_dbl_req_dat(o_dbl_req_dat),
    .i_dbl_rsp_val(i_dbl_rsp_val), .o_dbl_rsp_rdy(o_dbl_rsp_rdy), .i_dbl_rsp_dat(i_dbl_rsp_dat),
    .o_err(o_err), .o_busy(o_busy)
  );

  logic [FPW-1:0] src_pnt [MI];
  logic [FEW-1:0] src_scl [MI];
  logic [1:0]     src_mode = 2'd0;
  int src_n = 1, src_idx = 0, src_budget = 0;
  bit thr = 1'b0, out_hold = 1'b0, add_err_inj = 1'b0;
  int add_lat = 0;
  int n_beats = 0, n_add = 0, n_dbl = 0, n_res = 0;
  logic [FPW-1:0] res_dat = '0;
  logic [CB-1:0]  res_ctl = '0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pair stream source: loops over src_n pairs until src_budget beats are taken
  initial begin : src_agent
    bit fire;
    i_pnt_scl_val = 1'b0; i_pnt_scl_dat = '0; i_pnt_scl_ctl = '0;
    forever begin
      @(negedge clk);
      fire = i_pnt_scl_val && o_pnt_scl_rdy;
      @(posedge clk); #1;
      if (fire) begin
        n_beats++; src_budget--; src_idx = (src_idx + 1) % src_n;
      end
      if (src_budget > 0 && (i_pnt_scl_val || !thr || $urandom_range(0, 1) == 1)) begin
        i_pnt_scl_val = 1'b1;
        i_pnt_scl_dat = {src_pnt[src_idx], src_scl[src_idx]};
        i_pnt_scl_ctl = {6'b101010, src_mode};
      end else begin
        i_pnt_scl_val = 1'b0;
      end
    end
  end

  initial begin : add_unit
    bit fire; logic [FPW-1:0] sum; int lat, w;
    i_add_req_rdy = 1'b0; i_add_rsp_val = 1'b0; i_add_rsp_dat = '0; i_add_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      fire = o_add_req_val && i_add_req_rdy;
      sum  = o_add_req_dat[2*FPW-1:FPW] + o_add_req_dat[FPW-1:0];
      @(posedge clk); #1;
      if (fire) begin
        n_add++; i_add_req_rdy = 1'b0;
        lat = thr ? int'($urandom_range(0, 3)) : add_lat;
        repeat (lat) @(posedge clk);
        #1;
        i_add_rsp_val = 1'b1; i_add_rsp_dat = sum; i_add_rsp_err = add_err_inj; add_err_inj = 1'b0;
        w = 0;
        do begin @(negedge clk); fire = o_add_rsp_rdy; w++; end
        while (!fire && rst_n && w < 1000);
        @(posedge clk); #1;
        i_add_rsp_val = 1'b0; i_add_rsp_err = 1'b0;
      end
      i_add_req_rdy = !thr || $urandom_range(0, 1) == 1;
    end
  end

  initial begin : dbl_unit
    bit fire; logic [FPW-1:0] dv; int lat, w;
    i_dbl_req_rdy = 1'b0; i_dbl_rsp_val = 1'b0; i_dbl_rsp_dat = '0;
    forever begin
      @(negedge clk);
      fire = o_dbl_req_val && i_dbl_req_rdy;
      dv   = o_dbl_req_dat << 1;
      @(posedge clk); #1;
      if (fire) begin
        n_dbl++; i_dbl_req_rdy = 1'b0;
        lat = thr ? int'($urandom_range(0, 3)) : 0;
        repeat (lat) @(posedge clk);
        #1;
        i_dbl_rsp_val = 1'b1; i_dbl_rsp_dat = dv;
        w = 0;
        do begin @(negedge clk); fire = o_dbl_rsp_rdy; w++; end
        while (!fire && rst_n && w < 1000);
        @(posedge clk); #1;
        i_dbl_rsp_val = 1'b0;
      end
      i_dbl_req_rdy = !thr || $urandom_range(0, 1) == 1;
    end
  end

  initial begin : out_sink
    bit fire;
    i_pnt_rdy = 1'b0;
    forever begin
      @(negedge clk);
      fire = o_pnt_val && i_pnt_rdy;
      if (fire) begin res_dat = o_pnt_dat; res_ctl = o_pnt_ctl; end
      @(posedge clk); #1;
      if (fire) n_res++;
      i_pnt_rdy = !out_hold && (!thr || $urandom_range(0, 1) == 1);
    end
  end

  task automatic start_op(input logic [1:0] mode, input int n, input logic [NW-1:0] num, input int budget);
    @(negedge clk);
    src_mode = mode; src_n = n; src_idx = 0; i_num_in = num;
    n_beats = 0; n_add = 0; n_dbl = 0;
    src_budget = budget;
  endtask

  task automatic wait_result(input string tag);
    int t0, cyc;
    t0 = n_res; cyc = 0;
    while (n_res == t0 && cyc < 20000) begin @(negedge clk); cyc++; end
    chk({tag, "_done"}, 32'(n_res != t0), 32'd1);
  endtask

  initial begin : main
    logic [FPW-1:0] exp_sum;
    int bad, cyc;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_vals", 32'({o_pnt_val, o_add_req_val, o_dbl_req_val}), 32'd0);
    chk("rst_rdys", 32'({o_pnt_scl_rdy, o_add_rsp_rdy, o_dbl_rsp_rdy}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 5G + 3*(2G) = 11G; column 3 skipped, first set bit bypasses
    src_pnt[0] = 16'd1; src_scl[0] = 8'd5; src_pnt[1] = 16'd2; src_scl[1] = 8'd3;
    start_op(2'd0, 2, 4'd2, 8);
    wait_result("t1");
    chk("t1_res", 32'(res_dat), 32'd11);
    chk("t1_ctl", 32'(res_ctl), 32'hA8);
    chk("t1_adds", n_add, 3);
    chk("t1_dbls", n_dbl, 2);
    chk("t1_beats", n_beats, 8);
    chk("t1_err", 32'(o_err), 32'd0);

    for (int i = 0; i < 4; i++) begin src_pnt[i] = 16'(i + 1); src_scl[i] = 8'd0; end
    start_op(2'd0, 4, 4'd4, 16);
    wait_result("t2");
    chk("t2_res", 32'(res_dat), 32'd0);
    chk("t2_adds", n_add, 0);
    chk("t2_dbls", n_dbl, 0);
    chk("t2_beats", n_beats, 16);

    // mode 2, i_num_in ignored: 7G
    src_pnt[0] = 16'd1; src_scl[0] = 8'd7;
    start_op(2'd2, 1, 4'd5, 4);
    wait_result("t3a");
    chk("t3a_res", 32'(res_dat), 32'd7);
    chk("t3a_adds", n_add, 2);
    chk("t3a_dbls", n_dbl, 2);
    chk("t3a_beats", n_beats, 4);

    src_pnt[0] = 16'd1; src_scl[0] = 8'd9;
    start_op(2'd1, 1, 4'd3, 1);
    wait_result("t3b");
    chk("t3b_res", 32'(res_dat), 32'd8);
    chk("t3b_adds", n_add, 1);
    chk("t3b_beats", n_beats, 1);

    // scalar 2^(KB-1) with output back-pressure
    src_pnt[0] = 16'd1; src_scl[0] = 8'd8;
    out_hold = 1'b1;
    start_op(2'd2, 1, 4'd1, 4);
    cyc = 0;
    while (!o_pnt_val && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("t4_out_seen", 32'(o_pnt_val), 32'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_pnt_dat !== 16'd8 || o_pnt_val !== 1'b1 || o_pnt_scl_rdy !== 1'b0) bad++;
    end
    chk("t4_stall_stable", bad, 0);
    chk("t4_stall_beats", n_beats, 4);
    out_hold = 1'b0;
    wait_result("t4");
    chk("t4_res", 32'(res_dat), 32'd8);
    chk("t4_dbls", n_dbl, 3);
    chk("t4_adds", n_add, 0);

    src_pnt[0] = 16'd3; src_scl[0] = 8'd15;
    start_op(2'd3, 1, 4'd1, 1);
    wait_result("m3");
    chk("m3_res", 32'(res_dat), 32'd0);
    chk("m3_ctl", 32'(res_ctl), 32'hAB);
    chk("m3_err", 32'(o_err), 32'd1);
    chk("m3_beats", n_beats, 1);

    // previous result is infinity: load without an adder call, error cleared
    src_pnt[0] = 16'd5; src_scl[0] = 8'd0;
    start_op(2'd1, 1, 4'd1, 1);
    wait_result("ld");
    chk("ld_res", 32'(res_dat), 32'd5);
    chk("ld_adds", n_add, 0);
    chk("ld_err", 32'(o_err), 32'd0);

    src_pnt[0] = 16'd5; src_scl[0] = 8'd3;
    start_op(2'd0, 1, 4'd0, 4);
    wait_result("n0");
    chk("n0_res", 32'(res_dat), 32'd15);
    chk("n0_err", 32'(o_err), 32'd1);
    chk("n0_beats", n_beats, 4);

    thr = 1'b1;
    exp_sum = '0;
    for (int i = 0; i < MI; i++) begin
      src_pnt[i] = 16'($urandom_range(1, 60));
      src_scl[i] = 8'($urandom_range(0, 255));
      exp_sum = exp_sum + 16'(src_scl[i][3:0]) * src_pnt[i];
    end
    start_op(2'd0, MI, 4'(MI), MI * KB);
    wait_result("thr");
    chk("thr_res", 32'(res_dat), 32'(exp_sum));
    chk("thr_err", 32'(o_err), 32'd0);
    chk("thr_beats", n_beats, MI * KB);
    thr = 1'b0;
    repeat (3) @(negedge clk);

    // adder error on the single add of 2G + G
    src_pnt[0] = 16'd1; src_scl[0] = 8'd3;
    add_err_inj = 1'b1;
    start_op(2'd0, 1, 4'd1, 4);
    wait_result("ae");
    chk("ae_res", 32'(res_dat), 32'd3);
    chk("ae_err", 32'(o_err), 32'd1);
    repeat (5) @(negedge clk);
    chk("ae_err_sticky", 32'(o_err), 32'd1);
    src_pnt[0] = 16'd4; src_scl[0] = 8'd1;
    start_op(2'd2, 1, 4'd1, 4);
    wait_result("ec");
    chk("ec_res", 32'(res_dat), 32'd4);
    chk("ec_err", 32'(o_err), 32'd0);

    // reset while waiting on a slow adder
    add_lat = 6;
    src_pnt[0] = 16'd5; src_scl[0] = 8'd3;
    start_op(2'd0, 1, 4'd0, 4);
    cyc = 0;
    while (!o_add_rsp_rdy && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("rm_in_add_wait", 32'(o_add_rsp_rdy), 32'd1);
    chk("rm_err_before", 32'(o_err), 32'd1);
    rst_n = 1'b0;
    src_budget = 0;
    #1;
    chk("rm_busy", 32'(o_busy), 32'd0);
    chk("rm_err", 32'(o_err), 32'd0);
    chk("rm_rdys", 32'({o_pnt_scl_rdy, o_add_rsp_rdy, o_dbl_rsp_rdy}), 32'd0);
    chk("rm_vals", 32'({o_pnt_val, o_add_req_val, o_dbl_req_val}), 32'd0);
    repeat (10) @(negedge clk);
    chk("rm_held_busy", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
